// File: rtl/pb_uart_regs_irq.sv
// PicoBlaze port-mapped register file for the UART TX/RX FIFO pair, with baud divider and sticky edge interrupts.
// Read data and FIFO pulses are registered (1 cycle); interrupt follows the pending bits by one further cycle.
module pb_uart_regs_irq #(
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter int          DIV_WIDTH    = 16,
    parameter logic [31:0] DIV_RESET    = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic                 read_strobe,
    input  logic                 write_strobe,
    output logic                 interrupt,
    output logic                 buffer_write,
    output logic [7:0]           uart_data_write,
    output logic                 buffer_read,
    input  logic [7:0]           uart_data_read,
    input  logic                 rx_data_present,
    input  logic                 rx_half_full,
    input  logic                 rx_full,
    input  logic                 tx_data_present,
    input  logic                 tx_half_full,
    input  logic                 tx_full,
    output logic                 enable,
    output logic [DIV_WIDTH-1:0] uart_clock_divide
);
    localparam int NDIV = (DIV_WIDTH + 7) / 8;

    logic [7:0]           off;
    logic [7:0]           control;
    logic [5:0]           status;
    logic [5:0]           mask;
    logic [5:0]           pend;
    logic [5:0]           prev;
    logic [5:0]           clr;
    logic [NDIV*8-1:0]    div_ext;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic [7:0]           rd_nxt;

    assign off    = port_id - BASE_ADDRESS;
    assign status = {tx_full, tx_half_full, tx_data_present, rx_full, rx_half_full, rx_data_present};
    assign enable = control[0];
    assign clr    = (write_strobe && off == 8'd4) ? data_in[5:0] : 6'h00;

    // Zero-extended view of the divider so the top byte reads 0 above DIV_WIDTH.
    always_comb begin
        div_ext = '0;
        div_ext[DIV_WIDTH-1:0] = uart_clock_divide;
    end

    always_comb begin
        div_nxt = uart_clock_divide;
        for (int b = 0; b < DIV_WIDTH; b++) begin
            if (write_strobe && off == 8'(5 + b / 8))
                div_nxt[b] = data_in[b % 8];
        end
    end

    always_comb begin
        rd_nxt = 8'h00;
        case (off)
            8'd0:    rd_nxt = uart_data_read;
            8'd1:    rd_nxt = control;
            8'd2:    rd_nxt = {2'b00, status};
            8'd3:    rd_nxt = {2'b00, mask};
            8'd4:    rd_nxt = {2'b00, pend};
            default: rd_nxt = 8'h00;
        endcase
        for (int k = 0; k < NDIV; k++) begin
            if (off == 8'(5 + k))
                rd_nxt = div_ext[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out          <= 8'h00;
            control           <= 8'h00;
            mask              <= 6'h00;
            pend              <= 6'h00;
            prev              <= 6'h00;
            interrupt         <= 1'b0;
            buffer_write      <= 1'b0;
            buffer_read       <= 1'b0;
            uart_data_write   <= 8'h00;
            uart_clock_divide <= DIV_RESET[DIV_WIDTH-1:0];
        end else begin
            data_out          <= rd_nxt;
            buffer_write      <= write_strobe && off == 8'd0;
            buffer_read       <= read_strobe && off == 8'd0;
            uart_clock_divide <= div_nxt;
            if (write_strobe && off == 8'd0) uart_data_write <= data_in;
            if (write_strobe && off == 8'd1) control <= data_in;
            if (write_strobe && off == 8'd3) mask <= data_in[5:0];
            prev      <= status;
            // A new rising edge outranks a simultaneous write-1-to-clear.
            pend      <= (pend & ~clr) | (status & ~prev);
            interrupt <= |(pend & mask);
        end
    end
endmodule
